// File: rtl/axi_pulsegen_slave.sv
// AXI4-Lite slave with a four-register pulse generator (CTRL, PERIOD, WIDTH, COUNT).
// Define PULSEGEN_IRQ_EN to add a one-cycle irq output on run completion.
module axi_pulsegen_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                      AWPROT,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                      ARPROT,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic                            pulse_out,
  output logic                            busy
`ifdef PULSEGEN_IRQ_EN
  ,
  output logic                            irq
`endif
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] regs_d [4];
  logic          awready_q, awready_d;
  logic          bvalid_q, bvalid_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  state_t        state_q, state_d;
  logic          en_prev_q;
  logic [DW-1:0] phase_q, phase_d;
  logic [DW-1:0] pulses_q, pulses_d;
  logic [DW-1:0] per_s_q, per_s_d;
  logic [DW-1:0] wid_s_q, wid_s_d;
  logic [DW-1:0] cnt_s_q, cnt_s_d;
  logic          pulse_q, pulse_d;
  logic          busy_q, busy_d;
  logic          irq_q, irq_d;

  logic          wr_hs, rd_hs, enable;
  logic [1:0]    waddr, raddr;
  logic [NB-1:0] be;
  logic          unused_ok;

  assign wr_hs  = awready_q & AWVALID & WVALID;
  assign rd_hs  = arready_q & ARVALID;
  assign waddr  = AWADDR[3:2];
  assign raddr  = ARADDR[3:2];
  assign enable = regs_q[0][0];
  assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_be
      assign be[gi] = wr_hs & WSTRB[gi];
    end
  endgenerate

  always_comb begin
    regs_d    = regs_q;
    awready_d = AWVALID && WVALID && !bvalid_q && !awready_q;
    bvalid_d  = bvalid_q && !BREADY;
    arready_d = ARVALID && !rvalid_q && !arready_q;
    rvalid_d  = rvalid_q && !RREADY;
    rdata_d   = rdata_q;
    if (wr_hs) begin
      bvalid_d = 1'b1;
      for (int b = 0; b < NB; b++) begin
        if (be[b]) regs_d[waddr][8*b +: 8] = WDATA[8*b +: 8];
      end
    end
    // Reads sample regs_q, so a same-cycle write is not yet visible.
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[raddr];
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    pulses_d = pulses_q;
    per_s_d  = per_s_q;
    wid_s_d  = wid_s_q;
    cnt_s_d  = cnt_s_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && !en_prev_q && regs_q[1] != '0) begin
          state_d  = ST_RUN;
          phase_d  = '0;
          pulses_d = '0;
          per_s_d  = regs_q[1];
          wid_s_d  = regs_q[2];
          cnt_s_d  = regs_q[3];
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d  = ST_IDLE;
          phase_d  = '0;
          pulses_d = '0;
        end else if (phase_q == per_s_q - 1'b1) begin
          phase_d  = '0;
          pulses_d = pulses_q + 1'b1;
          if (cnt_s_q != '0 && pulses_q + 1'b1 == cnt_s_q) state_d = ST_DONE;
          // Shadow reload at the wrap; a zero PERIOD would never wrap, so keep the old one.
          if (regs_q[1] != '0) per_s_d = regs_q[1];
          wid_s_d = regs_q[2];
          cnt_s_d = regs_q[3];
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_DONE: begin
        phase_d = '0;
        if (!enable) begin
          state_d  = ST_IDLE;
          pulses_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pulse_d = (state_q == ST_RUN) && (state_d == ST_RUN) && (phase_q < wid_s_q);
    busy_d  = (state_d == ST_RUN);
    irq_d   = (state_q == ST_RUN) && (state_d == ST_DONE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      state_q   <= ST_IDLE;
      en_prev_q <= 1'b0;
      phase_q   <= '0;
      pulses_q  <= '0;
      per_s_q   <= '0;
      wid_s_q   <= '0;
      cnt_s_q   <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      state_q   <= state_d;
      en_prev_q <= enable;
      phase_q   <= phase_d;
      pulses_q  <= pulses_d;
      per_s_q   <= per_s_d;
      wid_s_q   <= wid_s_d;
      cnt_s_q   <= cnt_s_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      irq_q     <= irq_d;
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = awready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = 2'b00;
  assign ARREADY   = arready_q;
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_q;
  assign RRESP     = 2'b00;
  assign pulse_out = pulse_q;
  assign busy      = busy_q;
`ifdef PULSEGEN_IRQ_EN
  assign irq       = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_q;
`endif

endmodule

// File: tb/tb_axi_pulsegen_slave.sv
// Directed + randomized bench for axi_pulsegen_slave with a register/pulse reference model.
module tb_axi_pulsegen_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        pulse_out;
  logic        busy;
`ifdef PULSEGEN_IRQ_EN
  logic        irq;
`endif

  axi_pulsegen_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .pulse_out(pulse_out), .busy(busy)
`ifdef PULSEGEN_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 ACLK = ~ACLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [4];
  int          cyc = 0;
  bit          mon_en = 0;
  logic        mon_prev = 0;
  int          rises [$];

  always @(posedge ACLK) cyc++;
  always @(negedge ACLK) begin
    if (mon_en) begin
      if (pulse_out && !mon_prev) rises.push_back(cyc);
      mon_prev = pulse_out;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int bdelay);
    int t = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1; WVALID = 1;
    @(negedge ACLK);
    while (!AWREADY && t < 20) begin @(negedge ACLK); t++; end
    chk("awready", AWREADY, 1);
    chk("wready", WREADY, 1);
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    model_write(addr, data, strb);
    @(negedge ACLK);
    chk("bvalid_rise", BVALID, 1);
    chk("bresp", BRESP, 0);
    if (bdelay > 0) begin
      AWVALID = 1; WVALID = 1;
      repeat (bdelay) begin
        @(negedge ACLK);
        chk("bvalid_hold", BVALID, 1);
        chk("awready_blocked", AWREADY, 0);
      end
      AWVALID = 0; WVALID = 0;
    end
    BREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0;
    @(negedge ACLK);
    chk("bvalid_clear", BVALID, 0);
    $display("WR addr=%h data=%h strb=%h bdelay=%0d", addr, data, strb, bdelay);
  endtask

  task automatic axi_read(input logic [3:0] addr, input int rdelay, output logic [31:0] data);
    int t = 0;
    ARADDR = addr; ARVALID = 1;
    @(negedge ACLK);
    while (!ARREADY && t < 20) begin @(negedge ACLK); t++; end
    chk("arready", ARREADY, 1);
    @(posedge ACLK); #1;
    ARVALID = 0;
    @(negedge ACLK);
    chk("rvalid_rise", RVALID, 1);
    chk("rresp", RRESP, 0);
    data = RDATA;
    repeat (rdelay) begin
      @(negedge ACLK);
      chk("rvalid_hold", RVALID, 1);
      chk("rdata_stable", RDATA, data);
    end
    RREADY = 1;
    @(posedge ACLK); #1;
    RREADY = 0;
    $display("RD addr=%h data=%h rdelay=%0d", addr, data, rdelay);
  endtask

  task automatic read_check(input logic [3:0] addr, input int rdelay);
    logic [31:0] d;
    axi_read(addr, rdelay, d);
    chk("rdata", d, model[addr[3:2]]);
  endtask

  // Pulse n (sampled n cycles after busy rises) is high for n in 1..P*C-1 while (n-1) mod P < W.
  task automatic run_check(input int p, input int w, input int c);
    axi_write(4'h0, 32'h0, 4'hF, 0);
    axi_write(4'h4, p, 4'hF, 0);
    axi_write(4'h8, w, 4'hF, 0);
    axi_write(4'hC, c, 4'hF, 0);
    axi_write(4'h0, 32'h1, 4'hF, 0);
    for (int n = 0; n <= p * c + 2; n++) begin
      if (n > 0) @(negedge ACLK);
      chk("pulse_out", pulse_out, (n >= 1 && n < p * c && ((n - 1) % p) < w) ? 1 : 0);
      chk("busy", busy, (n < p * c) ? 1 : 0);
`ifdef PULSEGEN_IRQ_EN
      chk("irq", irq, (n == p * c) ? 1 : 0);
`endif
    end
    $display("RUN period=%0d width=%0d count=%0d", p, w, c);
  endtask

  initial begin
    logic [31:0] d;
    ARESETN = 0; AWADDR = 0; AWPROT = 0; AWVALID = 0; WDATA = 0; WSTRB = 0;
    WVALID = 0; BREADY = 0; ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 0;
    for (int i = 0; i < 4; i++) model[i] = 0;
    repeat (3) @(negedge ACLK);
    chk("rst_awready", AWREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_pulse", pulse_out, 0);
    chk("rst_busy", busy, 0);
`ifdef PULSEGEN_IRQ_EN
    chk("rst_irq", irq, 0);
`endif
    ARESETN = 1;
    @(negedge ACLK);
    for (int i = 0; i < 4; i++) read_check(4 * i, 0);

    for (int i = 0; i < 4; i++) axi_write(4 * i, i + 1, 4'hF, 0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4 * i, 0, d);
      chk("basic_rd", d, i + 1);
    end
    axi_write(4'h0, 32'h0, 4'hF, 0);

    axi_write(4'h4, 32'hAABBCCDD, 4'hF, 0);
    axi_write(4'h4, 32'h11223344, 4'b0101, 0);
    axi_read(4'h4, 0, d);
    chk("strobe_merge", d, 32'hAA22CC44);
    axi_write(4'h4, 32'hFFFFFFFF, 4'h0, 0);
    read_check(4'h4, 0);

    axi_write(4'h8, 32'h5A5A1234, 4'hF, 5);
    read_check(4'h8, 5);

    for (int k = 0; k < 10; k++) begin
      logic [3:0] a;
      a = {2'($urandom_range(1, 3)), 2'($urandom_range(0, 3))};
      axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3));
      read_check({a[3:2], 2'($urandom_range(0, 3))}, $urandom_range(0, 3));
    end

    run_check(10, 3, 2);
    for (int k = 0; k < 4; k++) begin
      int p;
      p = $urandom_range(2, 8);
      run_check(p, $urandom_range(0, p + 1), $urandom_range(1, 3));
    end

    axi_write(4'h0, 32'h0, 4'hF, 0);
    axi_write(4'h4, 6, 4'hF, 0);
    axi_write(4'h8, 3, 4'hF, 0);
    axi_write(4'hC, 0, 4'hF, 0);
    axi_write(4'h0, 1, 4'hF, 0);
    repeat (4) @(negedge ACLK);
    chk("run_busy", busy, 1);
    axi_write(4'h0, 0, 4'hF, 0);
    repeat (3) begin
      chk("disable_busy", busy, 0);
      chk("disable_pulse", pulse_out, 0);
      @(negedge ACLK);
    end

    axi_write(4'h4, 8, 4'hF, 0);
    axi_write(4'h8, 2, 4'hF, 0);
    rises.delete();
    mon_prev = 0;
    axi_write(4'h0, 1, 4'hF, 0);
    mon_en = 1;
    axi_write(4'h4, 4, 4'hF, 0);
    repeat (25) @(negedge ACLK);
    mon_en = 0;
    chk("shadow_nrises", (rises.size() >= 4) ? 1 : 0, 1);
    if (rises.size() >= 4) begin
      chk("shadow_old_period", rises[1] - rises[0], 8);
      chk("shadow_new_period", rises[2] - rises[1], 4);
      chk("shadow_new_period2", rises[3] - rises[2], 4);
    end
    axi_write(4'h0, 0, 4'hF, 0);

    axi_write(4'h4, 5, 4'hF, 0);
    axi_write(4'h8, 5, 4'hF, 0);
    axi_write(4'h0, 1, 4'hF, 0);
    repeat (3) @(negedge ACLK);
    chk("pre_rst_pulse", pulse_out, 1);
    chk("pre_rst_busy", busy, 1);
    begin
      int t = 0;
      AWADDR = 4'h8; WDATA = 32'h7; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
      @(negedge ACLK);
      while (!AWREADY && t < 20) begin @(negedge ACLK); t++; end
      @(posedge ACLK); #1;
      AWVALID = 0; WVALID = 0;
      @(negedge ACLK);
      chk("pre_rst_bvalid", BVALID, 1);
    end
    #2 ARESETN = 0;
    #1;
    chk("arst_pulse", pulse_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_bvalid", BVALID, 0);
`ifdef PULSEGEN_IRQ_EN
    chk("arst_irq", irq, 0);
`endif
    for (int i = 0; i < 4; i++) model[i] = 0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1;
    repeat (3) begin
      @(negedge ACLK);
      chk("post_rst_bvalid", BVALID, 0);
      chk("post_rst_busy", busy, 0);
    end
    for (int i = 0; i < 4; i++) read_check(4 * i, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
